mm_game_ctrl: RTL

Turn sequencer for the Mastermind game. It owns the game state machine: it latches a new secret code from the PRNG, gates guess entry, commits each guess to history, and scores the guess against the code. Scoring is sequential, one comparison per cycle. It drives the per-digit feedback symbols consumed by the SSD converters, plus the turn and game-over status. It sits between the guess/prng/history blocks and the feedback display path in the `mastermind` top level.

---
 rtl/mm_game_if.sv | 48 ++++
 rtl/mm_game_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_game_if.sv
// mm_game_if: signal bundle between the Mastermind turn sequencer and its
// neighbours (guess editor, PRNG, history store, feedback display path).
// The slave modport is the controller side; the master modport is the
// side that drives the button, mode switch, guess and PRNG code.
interface mm_game_if;
  logic       select;
  logic       mode;
  logic [2:0] guess0;
  logic [2:0] guess1;
  logic [2:0] guess2;
  logic [2:0] guess3;
  logic [2:0] code0;
  logic [2:0] code1;
  logic [2:0] code2;
  logic [2:0] code3;
  logic       code_ld;
  logic       entry_en;
  logic       hist_we;
  logic [2:0] hist_addr;
  logic [2:0] turn;
  logic [1:0] feedback0;
  logic [1:0] feedback1;
  logic [1:0] feedback2;
  logic [1:0] feedback3;
  logic       fb_valid;
  logic       busy;
  logic       game_over;
  logic       win;
  logic       dup_reject;

  modport master (
    output select, mode,
    output guess0, guess1, guess2, guess3,
    output code0, code1, code2, code3,
    input  code_ld, entry_en, hist_we, hist_addr, turn,
    input  feedback0, feedback1, feedback2, feedback3,
    input  fb_valid, busy, game_over, win, dup_reject
  );

  modport slave (
    input  select, mode,
    input  guess0, guess1, guess2, guess3,
    input  code0, code1, code2, code3,
    output code_ld, entry_en, hist_we, hist_addr, turn,
    output feedback0, feedback1, feedback2, feedback3,
    output fb_valid, busy, game_over, win, dup_reject
  );
endinterface

// File: rtl/mm_game_ctrl.sv
// mm_game_ctrl: Mastermind turn sequencer. Latches the secret code, gates
// guess entry, commits each guess to history and scores it one comparison
// per cycle (4 exact-position checks, then 16 colour-only checks), giving
// a fixed 22-cycle select-to-feedback latency.
// Optional feature macro: MM_DUP_CHECK_EN rejects guesses that repeat a
// colour; when undefined, dup_reject is tied low and duplicates are scored.
module mm_game_ctrl #(
  parameter int MAX_TURNS = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  mm_game_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_COMMIT,
    S_EXACT,
    S_PART,
    S_REPORT,
    S_DONE
  } state_t;

  localparam logic [2:0] LAST_TURN = 3'(MAX_TURNS - 1);

  state_t     state;
  state_t     state_nxt;
  logic       sel_q;
  logic       sel_ev;
  logic       dup_found;
  logic       entry_en_c;
  logic       hist_we_c;
  logic       busy_c;
  logic       fb_valid_c;
  logic       game_over_c;
  logic [2:0] g_in    [4];
  logic [2:0] code_in [4];
  logic [2:0] code_r  [4];
  logic [2:0] guess_r [4];
  logic [3:0] gu;
  logic [3:0] cu;
  logic [2:0] exact_cnt;
  logic [2:0] part_cnt;
  logic [2:0] scored;
  logic [1:0] idx_i;
  logic [1:0] idx_j;
  logic [2:0] turn_r;
  logic [1:0] fb_r    [4];
  logic [1:0] fb_new  [4];
  logic [1:0] fb_out  [4];
  logic       win_r;
  logic       code_ld_r;

  assign g_in[0]    = bus.guess0;
  assign g_in[1]    = bus.guess1;
  assign g_in[2]    = bus.guess2;
  assign g_in[3]    = bus.guess3;
  assign code_in[0] = bus.code0;
  assign code_in[1] = bus.code1;
  assign code_in[2] = bus.code2;
  assign code_in[3] = bus.code3;

  // A press counts only on its rising edge, and never while reviewing
  // history or while a guess is being scored.
  assign sel_ev = bus.select & ~sel_q & ~bus.mode & ~busy_c;

`ifdef MM_DUP_CHECK_EN
  logic dup_rej_r;

  assign dup_found = (g_in[0] == g_in[1]) | (g_in[0] == g_in[2]) |
                     (g_in[0] == g_in[3]) | (g_in[1] == g_in[2]) |
                     (g_in[1] == g_in[3]) | (g_in[2] == g_in[3]);

  // One-cycle reject pulse for a guess entered with a repeated colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dup_rej_r <= 1'b0;
    end else begin
      dup_rej_r <= (state == S_ENTRY) && sel_ev && dup_found;
    end
  end

  assign bus.dup_reject = dup_rej_r;
`else
  assign dup_found      = 1'b0;
  assign bus.dup_reject = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and the state-derived status outputs
  always_comb begin
    state_nxt   = state;
    entry_en_c  = 1'b0;
    hist_we_c   = 1'b0;
    busy_c      = 1'b0;
    fb_valid_c  = 1'b0;
    game_over_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_ev) state_nxt = S_ENTRY;
      end
      S_ENTRY: begin
        entry_en_c = 1'b1;
        if (sel_ev && !dup_found) state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        hist_we_c = 1'b1;
        busy_c    = 1'b1;
        state_nxt = S_EXACT;
      end
      S_EXACT: begin
        busy_c = 1'b1;
        if (idx_i == 2'd3) state_nxt = S_PART;
      end
      S_PART: begin
        busy_c = 1'b1;
        if (idx_i == 2'd3 && idx_j == 2'd3) state_nxt = S_REPORT;
      end
      S_REPORT: begin
        busy_c     = 1'b1;
        fb_valid_c = 1'b1;
        if (exact_cnt == 3'd4 || turn_r == LAST_TURN) state_nxt = S_DONE;
        else                                          state_nxt = S_ENTRY;
      end
      S_DONE: begin
        game_over_c = 1'b1;
        if (sel_ev) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pack the final counts into per-digit symbols: exacts first, then colour-only
  always_comb begin
    scored = exact_cnt + part_cnt;
    for (int k = 0; k < 4; k++) begin
      fb_new[k] = 2'b00;
      if (3'(k) < exact_cnt)   fb_new[k] = 2'b10;
      else if (3'(k) < scored) fb_new[k] = 2'b01;
    end
  end

  // Code capture, guess latch, sequential scoring, turn and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= 1'b0;
      code_r    <= '{default: '0};
      guess_r   <= '{default: '0};
      gu        <= '0;
      cu        <= '0;
      exact_cnt <= '0;
      part_cnt  <= '0;
      idx_i     <= '0;
      idx_j     <= '0;
      turn_r    <= '0;
      fb_r      <= '{default: '0};
      win_r     <= 1'b0;
      code_ld_r <= 1'b0;
    end else begin
      sel_q     <= bus.select;
      code_ld_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_ev) begin
            code_r    <= code_in;
            code_ld_r <= 1'b1;
            turn_r    <= '0;
            win_r     <= 1'b0;
          end
        end
        S_COMMIT: begin
          guess_r   <= g_in;
          gu        <= '0;
          cu        <= '0;
          exact_cnt <= '0;
          part_cnt  <= '0;
          idx_i     <= '0;
          idx_j     <= '0;
        end
        S_EXACT: begin
          if (guess_r[idx_i] == code_r[idx_i]) begin
            gu[idx_i] <= 1'b1;
            cu[idx_i] <= 1'b1;
            exact_cnt <= exact_cnt + 3'd1;
          end
          idx_i <= idx_i + 2'd1;
        end
        S_PART: begin
          if (!gu[idx_i] && !cu[idx_j] && guess_r[idx_i] == code_r[idx_j]) begin
            gu[idx_i] <= 1'b1;
            cu[idx_j] <= 1'b1;
            part_cnt  <= part_cnt + 3'd1;
          end
          idx_j <= idx_j + 2'd1;
          if (idx_j == 2'd3) idx_i <= idx_i + 2'd1;
        end
        S_REPORT: begin
          fb_r <= fb_new;
          if (exact_cnt == 3'd4)       win_r  <= 1'b1;
          else if (turn_r != LAST_TURN) turn_r <= turn_r + 3'd1;
        end
        S_DONE: begin
          if (sel_ev) begin
            fb_r  <= '{default: '0};
            win_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Fresh symbols are shown during REPORT itself; the register holds them after
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      fb_out[k] = (state == S_REPORT) ? fb_new[k] : fb_r[k];
    end
  end

  assign bus.code_ld   = code_ld_r;
  assign bus.entry_en  = entry_en_c;
  assign bus.hist_we   = hist_we_c;
  assign bus.hist_addr = turn_r;
  assign bus.turn      = turn_r;
  assign bus.feedback0 = fb_out[0];
  assign bus.feedback1 = fb_out[1];
  assign bus.feedback2 = fb_out[2];
  assign bus.feedback3 = fb_out[3];
  assign bus.fb_valid  = fb_valid_c;
  assign bus.busy      = busy_c;
  assign bus.game_over = game_over_c;
  assign bus.win       = win_r;

endmodule
